// File: rtl/ahb_prio_arbiter.sv
// AHB bus arbiter: fixed-priority grant with locked-transfer hold and SPLIT masking.
// Define AHB_ARB_RR_EN to compile in round-robin arbitration selected by rr_mode.
//
// state     | meaning
// ST_ARB    | normal arbitration on every hready edge
// ST_LOCKED | locked sequence in progress, grant frozen
// ST_RESP2  | second cycle of a two-cycle ERROR/RETRY/SPLIT response
module ahb_prio_arbiter #(
    parameter int NUM_MST = 16,
    parameter int DEF_MST = 0
) (
    input  logic               hclk,
    input  logic               hrst_n,
    input  logic [NUM_MST-1:0] hbusreqx,
    input  logic [NUM_MST-1:0] hlockx,
    input  logic [NUM_MST-1:0] hsplitx,
    input  logic               hready,
    input  logic [1:0]         hresp,
    input  logic               rr_mode,
    output logic [NUM_MST-1:0] hgrantx,
    output logic [3:0]         hmaster,
    output logic               hmastlock
);

    localparam logic [1:0] ST_ARB    = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_RESP2  = 2'd2;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    localparam logic [3:0]         DEF_IDX = 4'(DEF_MST);
    localparam logic [NUM_MST-1:0] DEF_GNT = {{(NUM_MST-1){1'b0}}, 1'b1} << DEF_MST;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic               lock_hold;
    logic               lock_next;
    logic [NUM_MST-1:0] split_mask;
    logic [NUM_MST-1:0] split_set;
    logic [NUM_MST-1:0] mask_next;
    logic [NUM_MST-1:0] eligible;
    logic [NUM_MST-1:0] winner_oh;
    logic [3:0]         grant_idx;
    logic [3:0]         lo_idx;
    logic [3:0]         rr_idx;
    logic [3:0]         winner_idx;
    logic               use_rr;
    logic               split_done;
    logic               arb_point;
    logic               owner_lock;
    logic               winner_lock;

    always_comb begin
        grant_idx = 4'd0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (hgrantx[i]) grant_idx = 4'(i);
        end
    end

    assign owner_lock = |(hlockx & hgrantx);
    assign split_done = (state == ST_RESP2) && hready && (hresp == RESP_SPLIT);

    always_comb begin
        split_set = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            split_set[i] = split_done && (hmaster == 4'(i));
        end
    end

    // A set from a completing SPLIT beats a same-cycle resume, and the new mask
    // already applies to the arbitration that the SPLIT forces.
    assign mask_next = (split_mask & ~hsplitx) | split_set;
    assign eligible  = hbusreqx & ~mask_next;
    assign arb_point = hready && (!lock_hold || split_done);

    always_comb begin
        lo_idx = DEF_IDX;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (eligible[i]) lo_idx = 4'(i);
        end
    end

`ifdef AHB_ARB_RR_EN
    logic [3:0] last_grant;
    logic [3:0] hi_idx;
    logic       hi_found;

    always_comb begin
        hi_idx   = DEF_IDX;
        hi_found = 1'b0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (eligible[i] && (4'(i) > last_grant)) begin
                hi_idx   = 4'(i);
                hi_found = 1'b1;
            end
        end
    end

    // Nothing above the last winner means the search wraps to the lowest index.
    assign rr_idx = hi_found ? hi_idx : lo_idx;
    assign use_rr = rr_mode;

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            last_grant <= DEF_IDX;
        end else if (arb_point) begin
            last_grant <= winner_idx;
        end
    end
`else
    logic unused_rr_mode;
    assign unused_rr_mode = rr_mode;
    assign rr_idx         = lo_idx;
    assign use_rr         = 1'b0;
`endif

    always_comb begin
        if (|eligible) begin
            winner_idx = use_rr ? rr_idx : lo_idx;
        end else begin
            winner_idx = DEF_IDX;
        end
    end

    always_comb begin
        winner_oh = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            winner_oh[i] = (winner_idx == 4'(i));
        end
    end

    assign winner_lock = |(hlockx & winner_oh);

    always_comb begin
        lock_next = lock_hold;
        if (arb_point) begin
            lock_next = winner_lock;
        end else if (hready && lock_hold && !owner_lock) begin
            lock_next = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ARB, ST_LOCKED: begin
                if (!hready && (hresp != RESP_OKAY)) begin
                    state_next = ST_RESP2;
                end else begin
                    state_next = lock_next ? ST_LOCKED : ST_ARB;
                end
            end
            ST_RESP2: begin
                // A RETRY inside a locked sequence leaves the lock in force.
                if (hready) state_next = lock_next ? ST_LOCKED : ST_ARB;
            end
            default: state_next = ST_ARB;
        endcase
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state      <= ST_ARB;
            lock_hold  <= 1'b0;
            split_mask <= '0;
            hgrantx    <= DEF_GNT;
            hmaster    <= DEF_IDX;
            hmastlock  <= 1'b0;
        end else begin
            state      <= state_next;
            lock_hold  <= lock_next;
            split_mask <= mask_next;
            if (arb_point) begin
                hgrantx <= winner_oh;
            end
            if (hready) begin
                hmaster   <= grant_idx;
                hmastlock <= owner_lock;
            end
        end
    end

endmodule

// File: tb/tb_ahb_prio_arbiter.sv
// Directed bench for ahb_prio_arbiter, NUM_MST=4, DEF_MST=0.
module tb_ahb_prio_arbiter;

    logic       hclk;
    logic       hrst_n;
    logic [3:0] hbusreqx;
    logic [3:0] hlockx;
    logic [3:0] hsplitx;
    logic       hready;
    logic [1:0] hresp;
    logic       rr_mode;
    logic [3:0] hgrantx;
    logic [3:0] hmaster;
    logic       hmastlock;

    int n_chk;
    int n_pass;

    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] RETRY = 2'b10;
    localparam logic [1:0] SPLIT = 2'b11;

    ahb_prio_arbiter #(.NUM_MST(4), .DEF_MST(0)) dut (
        .hclk      (hclk),
        .hrst_n    (hrst_n),
        .hbusreqx  (hbusreqx),
        .hlockx    (hlockx),
        .hsplitx   (hsplitx),
        .hready    (hready),
        .hresp     (hresp),
        .rr_mode   (rr_mode),
        .hgrantx   (hgrantx),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] rr_exp [4];

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        hrst_n   = 1'b0;
        hbusreqx = 4'b0000;
        hlockx   = 4'b0000;
        hsplitx  = 4'b0000;
        hready   = 1'b1;
        hresp    = OKAY;
        rr_mode  = 1'b0;

        repeat (2) tick();
        chk("rst_grant", 32'(hgrantx), 32'h1);
        chk("rst_hmaster", 32'(hmaster), 32'h0);
        chk("rst_mastlock", 32'(hmastlock), 32'h0);
        chk("rst_split", 32'(dut.split_mask), 32'h0);
        chk("rst_state", 32'(dut.state), 32'h0);
        hrst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_grant", 32'(hgrantx), 32'h1);
            chk("idle_hmaster", 32'(hmaster), 32'h0);
        end

        hbusreqx = 4'b1010;
        tick();
        chk("fp_grant", 32'(hgrantx), 32'b0010);
        chk("fp_hmaster_lag", 32'(hmaster), 32'h0);
        tick();
        chk("fp_hmaster", 32'(hmaster), 32'h1);

        hready   = 1'b0;
        hbusreqx = 4'b1000;
        tick();
        chk("nready_grant", 32'(hgrantx), 32'b0010);
        chk("nready_hmaster", 32'(hmaster), 32'h1);
        hready = 1'b1;
        tick();
        chk("ready_grant", 32'(hgrantx), 32'b1000);
        tick();
        chk("ready_hmaster", 32'(hmaster), 32'h3);

        hrst_n = 1'b0;
        #1;
        hrst_n   = 1'b1;
        hbusreqx = 4'b1111;
        rr_mode  = 1'b1;
`ifdef AHB_ARB_RR_EN
        rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;
`else
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0001; rr_exp[2] = 4'b0001; rr_exp[3] = 4'b0001;
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_seq", 32'(hgrantx), 32'(rr_exp[i]));
        end
        rr_mode = 1'b0;

        hbusreqx = 4'b0100;
        hlockx   = 4'b0100;
        tick();
        chk("lock_grant", 32'(hgrantx), 32'b0100);
        hbusreqx = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lock_hold_grant", 32'(hgrantx), 32'b0100);
            chk("lock_mastlock", 32'(hmastlock), 32'h1);
            chk("lock_state", 32'(dut.state), 32'h1);
        end

        hresp  = RETRY;
        hready = 1'b0;
        tick();
        chk("retry_state", 32'(dut.state), 32'h2);
        hready = 1'b1;
        tick();
        chk("retry_grant", 32'(hgrantx), 32'b0100);
        chk("retry_state2", 32'(dut.state), 32'h1);
        chk("retry_split", 32'(dut.split_mask), 32'h0);
        hresp = OKAY;

        hlockx = 4'b0000;
        tick();
        chk("unlock_grant_held", 32'(hgrantx), 32'b0100);
        chk("unlock_mastlock", 32'(hmastlock), 32'h0);
        tick();
        chk("unlock_grant", 32'(hgrantx), 32'b0001);

        hbusreqx = 4'b0100;
        hlockx   = 4'b0100;
        repeat (2) tick();
        chk("relock_mastlock", 32'(hmastlock), 32'h1);
        hrst_n = 1'b0;
        #1;
        chk("rst_lock_grant", 32'(hgrantx), 32'b0001);
        chk("rst_lock_mastlock", 32'(hmastlock), 32'h0);
        chk("rst_lock_state", 32'(dut.state), 32'h0);
        hlockx   = 4'b0000;
        hbusreqx = 4'b0010;
        hready   = 1'b0;
        #1;
        hrst_n = 1'b1;
        tick();
        chk("post_rst_nready", 32'(hgrantx), 32'b0001);
        hready = 1'b1;
        tick();
        chk("post_rst_arb", 32'(hgrantx), 32'b0010);

        hbusreqx = 4'b1000;
        repeat (2) tick();
        chk("split_pre_hmaster", 32'(hmaster), 32'h3);
        hresp  = SPLIT;
        hready = 1'b0;
        tick();
        chk("split_resp2", 32'(dut.state), 32'h2);
        hready = 1'b1;
        tick();
        chk("split_mask_set", 32'(dut.split_mask), 32'b1000);
        chk("split_grant_def", 32'(hgrantx), 32'b0001);
        chk("split_state_arb", 32'(dut.state), 32'h0);
        hresp = OKAY;
        tick();
        chk("split_masked_grant", 32'(hgrantx), 32'b0001);
        hsplitx = 4'b1000;
        tick();
        hsplitx = 4'b0000;
        chk("resume_grant", 32'(hgrantx), 32'b1000);
        chk("resume_mask", 32'(dut.split_mask), 32'h0);

        tick();
        chk("split2_hmaster", 32'(hmaster), 32'h3);
        hresp  = SPLIT;
        hready = 1'b0;
        tick();
        hready  = 1'b1;
        hsplitx = 4'b1000;
        tick();
        hsplitx = 4'b0000;
        hresp   = OKAY;
        chk("set_wins_mask", 32'(dut.split_mask), 32'b1000);
        chk("set_wins_grant", 32'(hgrantx), 32'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
